// File: rtl/rmw_counter_engine.sv
// Counter bank controller for a 2R/1W memory atom: initialises all counters, then
// performs pipelined read-modify-write increments and queries with result forwarding.
module rmw_counter_engine #(
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITDATA    = 8,
  parameter int SRAM_DELAY = 0,
  parameter int RSTSTRT    = 0,
  parameter int RSTINCR    = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               upd_vld,
  input  logic [BITADDR-1:0] upd_adr,
  input  logic [BITDATA-1:0] upd_inc,
  input  logic               qry_vld,
  input  logic [BITADDR-1:0] qry_adr,
  output logic               qry_dout_vld,
  output logic [BITDATA-1:0] qry_dout,
  output logic               read_0,
  output logic [BITADDR-1:0] rd_adr_0,
  input  logic [BITDATA-1:0] rd_dout_0,
  output logic               read_1,
  output logic [BITADDR-1:0] rd_adr_1,
  input  logic [BITDATA-1:0] rd_dout_1,
  output logic               write_2,
  output logic [BITADDR-1:0] wr_adr_2,
  output logic [BITDATA-1:0] wr_din_2
);

  localparam int HN = SRAM_DELAY + 1;
  localparam logic [BITADDR-1:0] LAST  = BITADDR'(NUMADDR - 1);
  localparam logic [BITDATA-1:0] START = BITDATA'(RSTSTRT);
  localparam logic [BITDATA-1:0] INCR  = BITDATA'(RSTINCR);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic [BITADDR-1:0] init_cnt;
  logic [BITDATA-1:0] init_val;
  logic               ready_q;

  // History entry 0 is the write stage itself; deeper entries are older results.
  logic               h_vld [HN];
  logic [BITADDR-1:0] h_adr [HN];
  logic [BITDATA-1:0] h_dat [HN];

  logic               wr_vld_nxt;
  logic [BITADDR-1:0] wr_adr_nxt;
  logic [BITDATA-1:0] wr_dat_nxt;

  logic               upd_acc, qry_acc;
  logic               c_vld;
  logic [BITADDR-1:0] c_adr;
  logic [BITDATA-1:0] c_inc, c_sum;
  logic               o_vld;
  logic [BITADDR-1:0] o_adr;

  function automatic logic [BITDATA-1:0] fwd(input logic [BITADDR-1:0] a,
                                             input logic [BITDATA-1:0] dflt);
    logic               hit;
    logic [BITDATA-1:0] v;
    hit = 1'b0;
    v   = dflt;
    for (int unsigned k = 0; k < HN; k++) begin
      if (!hit && h_vld[k] && (h_adr[k] == a)) begin
        v   = h_dat[k];
        hit = 1'b1;
      end
    end
    return v;
  endfunction

  assign ready    = ready_q;
  assign upd_acc  = ready_q & upd_vld;
  assign qry_acc  = ready_q & qry_vld;
  assign read_0   = upd_acc;
  assign rd_adr_0 = ready_q ? upd_adr : '0;
  assign read_1   = qry_acc;
  assign rd_adr_1 = ready_q ? qry_adr : '0;

  generate
    if (SRAM_DELAY == 0) begin : g_nodly
      assign c_vld = upd_acc;
      assign c_adr = upd_adr;
      assign c_inc = upd_inc;
      assign o_vld = qry_acc;
      assign o_adr = qry_adr;
    end else begin : g_dly
      logic               p_vld [SRAM_DELAY];
      logic [BITADDR-1:0] p_adr [SRAM_DELAY];
      logic [BITDATA-1:0] p_inc [SRAM_DELAY];
      logic               q_vld [SRAM_DELAY];
      logic [BITADDR-1:0] q_adr [SRAM_DELAY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned k = 0; k < SRAM_DELAY; k++) begin
            p_vld[k] <= 1'b0;
            p_adr[k] <= '0;
            p_inc[k] <= '0;
            q_vld[k] <= 1'b0;
            q_adr[k] <= '0;
          end
        end else begin
          p_vld[0] <= upd_acc;
          p_adr[0] <= upd_adr;
          p_inc[0] <= upd_inc;
          q_vld[0] <= qry_acc;
          q_adr[0] <= qry_adr;
          for (int unsigned k = 1; k < SRAM_DELAY; k++) begin
            p_vld[k] <= p_vld[k-1];
            p_adr[k] <= p_adr[k-1];
            p_inc[k] <= p_inc[k-1];
            q_vld[k] <= q_vld[k-1];
            q_adr[k] <= q_adr[k-1];
          end
        end
      end

      assign c_vld = p_vld[SRAM_DELAY-1];
      assign c_adr = p_adr[SRAM_DELAY-1];
      assign c_inc = p_inc[SRAM_DELAY-1];
      assign o_vld = q_vld[SRAM_DELAY-1];
      assign o_adr = q_adr[SRAM_DELAY-1];
    end
  endgenerate

  assign c_sum        = fwd(c_adr, rd_dout_0) + c_inc;
  assign qry_dout_vld = o_vld;
  assign qry_dout     = o_vld ? fwd(o_adr, rd_dout_1) : '0;

  always_comb begin
    state_nxt  = state;
    wr_vld_nxt = c_vld;
    wr_adr_nxt = c_adr;
    wr_dat_nxt = c_sum;
    if (state == ST_INIT) begin
      wr_vld_nxt = 1'b1;
      wr_adr_nxt = init_cnt;
      wr_dat_nxt = init_val;
      if (init_cnt == LAST) state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      init_val <= START;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state == ST_RUN);
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        init_val <= init_val + INCR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < HN; k++) begin
        h_vld[k] <= 1'b0;
        h_adr[k] <= '0;
        h_dat[k] <= '0;
      end
    end else begin
      h_vld[0] <= wr_vld_nxt;
      h_adr[0] <= wr_adr_nxt;
      h_dat[0] <= wr_dat_nxt;
      for (int unsigned k = 1; k < HN; k++) begin
        h_vld[k] <= h_vld[k-1];
        h_adr[k] <= h_adr[k-1];
        h_dat[k] <= h_dat[k-1];
      end
    end
  end

  assign write_2  = h_vld[0];
  assign wr_adr_2 = h_adr[0];
  assign wr_din_2 = h_dat[0];

endmodule

// File: tb/tb_rmw_counter_engine.sv
// Bench for rmw_counter_engine: instance 0 uses a 2-cycle memory, instance 1 a
// zero-latency memory; writes and query results are checked against a scoreboard.
module tb_rmw_counter_engine;

  typedef struct {
    logic [2:0] adr;
    logic [7:0] dat;
    int         cyc;
  } ent_t;

  logic       clk;
  logic       rst_a        [2];
  logic       ready_a      [2];
  logic       upd_vld_a    [2];
  logic [2:0] upd_adr_a    [2];
  logic [7:0] upd_inc_a    [2];
  logic       qry_vld_a    [2];
  logic [2:0] qry_adr_a    [2];
  logic       qry_dout_vld_a [2];
  logic [7:0] qry_dout_a   [2];
  logic       read_0_a     [2];
  logic [2:0] rd_adr_0_a   [2];
  logic [7:0] rd_dout_0_a  [2];
  logic       read_1_a     [2];
  logic [2:0] rd_adr_1_a   [2];
  logic [7:0] rd_dout_1_a  [2];
  logic       write_2_a    [2];
  logic [2:0] wr_adr_2_a   [2];
  logic [7:0] wr_din_2_a   [2];

  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  logic [7:0] d1_0, d2_0, d1_1, d2_1;
  logic [7:0] model [2][8];
  int         cyc;
  int         tests_run;
  int         failed;
  bit         mon_on [2];
  ent_t       wq0[$], wq1[$], qq0[$], qq1[$];

  rmw_counter_engine #(.NUMADDR(8), .BITADDR(3), .BITDATA(8), .SRAM_DELAY(2),
                       .RSTSTRT(16), .RSTINCR(1)) u_dut0 (
    .clk(clk), .rst(rst_a[0]), .ready(ready_a[0]),
    .upd_vld(upd_vld_a[0]), .upd_adr(upd_adr_a[0]), .upd_inc(upd_inc_a[0]),
    .qry_vld(qry_vld_a[0]), .qry_adr(qry_adr_a[0]),
    .qry_dout_vld(qry_dout_vld_a[0]), .qry_dout(qry_dout_a[0]),
    .read_0(read_0_a[0]), .rd_adr_0(rd_adr_0_a[0]), .rd_dout_0(rd_dout_0_a[0]),
    .read_1(read_1_a[0]), .rd_adr_1(rd_adr_1_a[0]), .rd_dout_1(rd_dout_1_a[0]),
    .write_2(write_2_a[0]), .wr_adr_2(wr_adr_2_a[0]), .wr_din_2(wr_din_2_a[0]));

  rmw_counter_engine #(.NUMADDR(8), .BITADDR(3), .BITDATA(8), .SRAM_DELAY(0),
                       .RSTSTRT(16), .RSTINCR(64)) u_dut1 (
    .clk(clk), .rst(rst_a[1]), .ready(ready_a[1]),
    .upd_vld(upd_vld_a[1]), .upd_adr(upd_adr_a[1]), .upd_inc(upd_inc_a[1]),
    .qry_vld(qry_vld_a[1]), .qry_adr(qry_adr_a[1]),
    .qry_dout_vld(qry_dout_vld_a[1]), .qry_dout(qry_dout_a[1]),
    .read_0(read_0_a[1]), .rd_adr_0(rd_adr_0_a[1]), .rd_dout_0(rd_dout_0_a[1]),
    .read_1(read_1_a[1]), .rd_adr_1(rd_adr_1_a[1]), .rd_dout_1(rd_dout_1_a[1]),
    .write_2(write_2_a[1]), .wr_adr_2(wr_adr_2_a[1]), .wr_din_2(wr_din_2_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory atoms: read-before-write, instance 0 with two cycles of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write_2_a[0]) mem0[wr_adr_2_a[0]] <= wr_din_2_a[0];
    if (write_2_a[1]) mem1[wr_adr_2_a[1]] <= wr_din_2_a[1];
    d1_0 <= mem0[rd_adr_0_a[0]];
    d2_0 <= d1_0;
    d1_1 <= mem0[rd_adr_1_a[0]];
    d2_1 <= d1_1;
  end
  assign rd_dout_0_a[0] = d2_0;
  assign rd_dout_1_a[0] = d2_1;
  assign rd_dout_0_a[1] = mem1[rd_adr_0_a[1]];
  assign rd_dout_1_a[1] = mem1[rd_adr_1_a[1]];

  function automatic int dly(input int b);
    return (b == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] incr_of(input int b);
    return (b == 0) ? 8'h01 : 8'h40;
  endfunction

  task automatic model_reset(input int b);
    for (int i = 0; i < 8; i++) model[b][i] = 8'(16 + i * int'(incr_of(b)));
  endtask

  task automatic zero_inputs();
    for (int b = 0; b < 2; b++) begin
      upd_vld_a[b] = 1'b0; upd_adr_a[b] = '0; upd_inc_a[b] = '0;
      qry_vld_a[b] = 1'b0; qry_adr_a[b] = '0;
    end
  endtask

  task automatic drive(input int b, input bit uv, input logic [2:0] ua, input logic [7:0] ui,
                       input bit qv, input logic [2:0] qa);
    ent_t e;
    @(posedge clk);
    #1;
    upd_vld_a[b] = uv; upd_adr_a[b] = ua; upd_inc_a[b] = ui;
    qry_vld_a[b] = qv; qry_adr_a[b] = qa;
    if (qv) begin
      e.adr = qa; e.dat = model[b][qa]; e.cyc = cyc + dly(b);
      if (b == 0) qq0.push_back(e); else qq1.push_back(e);
    end
    if (uv) begin
      model[b][ua] = model[b][ua] + ui;
      e.adr = ua; e.dat = model[b][ua]; e.cyc = cyc + dly(b) + 1;
      if (b == 0) wq0.push_back(e); else wq1.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    @(posedge clk);
    #1;
    zero_inputs();
    n = 0;
    while ((wq0.size() + wq1.size() + qq0.size() + qq1.size()) != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if ((wq0.size() + wq1.size() + qq0.size() + qq1.size()) != 0) begin
      failed++;
      $display("FAIL drain pending w0=%0d w1=%0d q0=%0d q1=%0d exp all 0",
               wq0.size(), wq1.size(), qq0.size(), qq1.size());
      wq0.delete(); wq1.delete(); qq0.delete(); qq1.delete();
    end
  endtask

  task automatic scoreboard();
    ent_t e;
    forever begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        if (mon_on[b] && write_2_a[b]) begin
          tests_run++;
          if (((b == 0) ? wq0.size() : wq1.size()) == 0) begin
            failed++;
            $display("FAIL sb_write%0d unexpected adr=%0h din=%0h cyc=%0d exp no write",
                     b, wr_adr_2_a[b], wr_din_2_a[b], cyc);
          end else begin
            e = (b == 0) ? wq0.pop_front() : wq1.pop_front();
            if ({wr_adr_2_a[b], wr_din_2_a[b], cyc} !== {e.adr, e.dat, e.cyc}) begin
              failed++;
              $display("FAIL sb_write%0d got adr=%0h din=%0h cyc=%0d exp adr=%0h din=%0h cyc=%0d",
                       b, wr_adr_2_a[b], wr_din_2_a[b], cyc, e.adr, e.dat, e.cyc);
            end
          end
        end
        if (mon_on[b] && qry_dout_vld_a[b]) begin
          tests_run++;
          if (((b == 0) ? qq0.size() : qq1.size()) == 0) begin
            failed++;
            $display("FAIL sb_query%0d unexpected dout=%0h cyc=%0d exp no result",
                     b, qry_dout_a[b], cyc);
          end else begin
            e = (b == 0) ? qq0.pop_front() : qq1.pop_front();
            if ({qry_dout_a[b], cyc} !== {e.dat, e.cyc}) begin
              failed++;
              $display("FAIL sb_query%0d adr=%0h got dout=%0h cyc=%0d exp dout=%0h cyc=%0d",
                       b, e.adr, qry_dout_a[b], cyc, e.dat, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int b = 0; b < 2; b++) begin
      rst_a[b] = 1'b0;
      upd_vld_a[b] = 1'b1; upd_adr_a[b] = 3'd5; upd_inc_a[b] = 8'h01;
      qry_vld_a[b] = 1'b1; qry_adr_a[b] = 3'd5;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      tests_run++;
      if ({ready_a[b], write_2_a[b], qry_dout_vld_a[b], read_0_a[b], read_1_a[b],
           wr_adr_2_a[b], wr_din_2_a[b], rd_adr_0_a[b]} !== 19'd0) begin
        failed++;
        $display("FAIL reset%0d got rdy=%0b wr=%0b qv=%0b r0=%0b r1=%0b wadr=%0h wdin=%0h radr=%0h exp all 0",
                 b, ready_a[b], write_2_a[b], qry_dout_vld_a[b], read_0_a[b], read_1_a[b],
                 wr_adr_2_a[b], wr_din_2_a[b], rd_adr_0_a[b]);
      end
    end
    zero_inputs();
  endtask

  task automatic test_init(input int b);
    logic [7:0] exp_din;
    model_reset(b);
    @(posedge clk);
    #1;
    rst_a[b] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      upd_vld_a[b] = (i == 2); upd_adr_a[b] = 3'd1; upd_inc_a[b] = 8'h05;
      @(negedge clk);
      exp_din = 8'(16 + i * int'(incr_of(b)));
      tests_run++;
      if ({write_2_a[b], wr_adr_2_a[b], wr_din_2_a[b], ready_a[b], read_0_a[b]} !==
          {1'b1, 3'(i), exp_din, 1'b0, 1'b0}) begin
        failed++;
        $display("FAIL init%0d_step%0d got wr=%0b adr=%0h din=%0h rdy=%0b r0=%0b exp 1 %0h %0h 0 0",
                 b, i, write_2_a[b], wr_adr_2_a[b], wr_din_2_a[b], ready_a[b], read_0_a[b],
                 3'(i), exp_din);
      end
    end
    @(posedge clk);
    #1;
    zero_inputs();
    @(negedge clk);
    tests_run++;
    if ({ready_a[b], write_2_a[b]} !== 2'b10) begin
      failed++;
      $display("FAIL init%0d_ready got rdy=%0b wr=%0b exp rdy=1 wr=0", b, ready_a[b], write_2_a[b]);
    end
    mon_on[b] = 1'b1;
  endtask

  task automatic test_single_update();
    drive(0, 1, 3'd3, 8'h05, 0, 3'd0);
    #1;
    tests_run++;
    if ({read_0_a[0], rd_adr_0_a[0]} !== {1'b1, 3'd3}) begin
      failed++;
      $display("FAIL single_read got r0=%0b adr=%0h exp r0=1 adr=3", read_0_a[0], rd_adr_0_a[0]);
    end
    repeat (3) drive(0, 0, 3'd0, 8'h00, 0, 3'd0);
    drive(0, 0, 3'd0, 8'h00, 1, 3'd3);
    drain();
  endtask

  task automatic test_hazard();
    repeat (4) drive(0, 1, 3'd2, 8'h01, 0, 3'd0);
    drain();
  endtask

  task automatic test_wrap();
    drive(0, 1, 3'd7, 8'hF0, 0, 3'd0);
    drive(0, 0, 3'd0, 8'h00, 1, 3'd7);
    repeat (4) drive(0, 0, 3'd0, 8'h00, 0, 3'd0);
    drive(0, 0, 3'd0, 8'h00, 1, 3'd7);
    drain();
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 3'd5, 8'h02, 1, 3'd5);
    drive(0, 0, 3'd0, 8'h00, 1, 3'd5);
    drain();
  endtask

  task automatic test_zero_delay();
    repeat (4) drive(1, 1, 3'd2, 8'h01, 1, 3'd2);
    drive(1, 0, 3'd0, 8'h00, 1, 3'd4);
    drive(1, 1, 3'd6, 8'hC0, 1, 3'd2);
    drive(1, 0, 3'd0, 8'h00, 1, 3'd6);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 50; n++) begin
        drive(b, bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
      end
      drain();
    end
  endtask

  task automatic test_reset_midop();
    repeat (3) drive(0, 1, 3'd1, 8'h11, 0, 3'd0);
    #1;
    mon_on[0] = 1'b0;
    rst_a[0] = 1'b0;
    wq0.delete();
    qq0.delete();
    @(negedge clk);
    tests_run++;
    if ({write_2_a[0], ready_a[0], read_0_a[0]} !== 3'b000) begin
      failed++;
      $display("FAIL midop_reset got wr=%0b rdy=%0b r0=%0b exp 0 0 0",
               write_2_a[0], ready_a[0], read_0_a[0]);
    end
    @(posedge clk);
    #1;
    zero_inputs();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests_run++;
      if (write_2_a[0] !== 1'b0) begin
        failed++;
        $display("FAIL midop_nowrite%0d got wr=%0b adr=%0h exp wr=0", n, write_2_a[0], wr_adr_2_a[0]);
      end
    end
    test_init(0);
    for (int i = 0; i < 8; i++) drive(0, 0, 3'd0, 8'h00, 1, 3'(i));
    drain();
  endtask

  initial begin
    cyc = 0;
    tests_run = 0;
    failed = 0;
    mon_on[0] = 1'b0;
    mon_on[1] = 1'b0;
    zero_inputs();
    fork
      scoreboard();
    join_none
    test_reset();
    test_init(0);
    test_init(1);
    test_single_update();
    test_hazard();
    test_wrap();
    test_same_cycle();
    test_zero_delay();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/rmw_counter_engine.md
Name: rmw_counter_engine

Overview:
- Client-side controller that drives a 2-read/1-write memory atom as a bank of NUMADDR saturating-free, wrap-around counters.
- Initialises every counter after reset, accepts one increment request and one query per cycle, and performs pipelined read-modify-write with hazard forwarding.
- Sits between the stats/update logic and the memory atom. It owns the atom's read_0 port (update reads), read_1 port (queries) and write_2 port.

Parameters:
- NUMADDR, 8, number of counters (memory depth).
- BITADDR, 3, address width; NUMADDR <= 2^BITADDR.
- BITDATA, 8, counter width.
- SRAM_DELAY, 0, memory read latency in cycles, from read strobe to rd_dout valid. Legal range 0..4.
- RSTSTRT, 0, initial value written to address 0.
- RSTINCR, 0, per-address increment of the initial value.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ready  out  1  high once initialisation is complete.
- upd_vld  in  1  increment request.
- upd_adr  in  BITADDR  counter address.
- upd_inc  in  BITDATA  increment amount.
- qry_vld  in  1  query request.
- qry_adr  in  BITADDR  query address.
- qry_dout_vld  out  1  query result valid.
- qry_dout  out  BITDATA  query result.
- read_0  out  1  memory read strobe, update path.
- rd_adr_0  out  BITADDR  memory read address, update path.
- rd_dout_0  in  BITDATA  memory read data, update path.
- read_1  out  1  memory read strobe, query path.
- rd_adr_1  out  BITADDR  memory read address, query path.
- rd_dout_1  in  BITDATA  memory read data, query path.
- write_2  out  1  memory write strobe.
- wr_adr_2  out  BITADDR  memory write address.
- wr_din_2  out  BITDATA  memory write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM enters INIT with init counter = 0.
  - ready, write_2, qry_dout_vld and all pipeline valid bits are 0.
  - Address and data outputs are 0.
  - Assertion mid-operation drops all in-flight updates and queries; no partial write is issued.
- FSM INIT:
  - Each cycle: write_2=1, wr_adr_2=i, wr_din_2=(RSTSTRT + i*RSTINCR) mod 2^BITDATA.
  - i runs 0..NUMADDR-1, one per cycle, starting on the first clock edge after rst deasserts.
  - After i=NUMADDR-1 the FSM moves to RUN; ready=1 from the next cycle.
  - read_0/read_1 stay 0 in INIT. upd_vld/qry_vld are ignored whenever ready=0, with no buffering.
- FSM RUN:
  - RUN is left only by reset.
  - read_0 = upd_vld and rd_adr_0 = upd_adr, combinational, same cycle.
  - read_1 = qry_vld and rd_adr_1 = qry_adr, combinational.
- Update pipeline:
  - Request at cycle t carries (adr, inc) through SRAM_DELAY stages.
  - At cycle t+SRAM_DELAY (compute stage): result = (base + inc) mod 2^BITDATA. The carry is discarded, so counters wrap.
  - Result is registered; write_2=1, wr_adr_2=adr, wr_din_2=result at cycle t+SRAM_DELAY+1.
  - Fixed latency: SRAM_DELAY+1. Throughput: one update per cycle, no backpressure.
- Forwarding:
  - The engine keeps a history of the last SRAM_DELAY+1 computed (adr, result) pairs, including results computed in earlier cycles that are not yet written.
  - base = result of the newest matching entry in the history, else rd_dout_0.
  - Back-to-back updates to one address must accumulate exactly.
- Query path:
  - Query at cycle t yields qry_dout_vld=1 at cycle t+SRAM_DELAY (combinational when SRAM_DELAY=0).
  - qry_dout = value reflecting every update accepted in cycles < t. It uses the same forwarding history, else rd_dout_1.
  - An update accepted in the same cycle t is not reflected.
- Simultaneous update and query to the same address in one cycle are legal; the query returns the pre-update value.
- write_2 never asserts twice to different addresses in one cycle; at most one write per cycle by construction.

Test Plan (NUMADDR=8, BITDATA=8, SRAM_DELAY=2, RSTSTRT=0x10, RSTINCR=1 unless stated):
- Init: release rst -> write_2 on 8 consecutive cycles with adr 0..7 and din 0x10..0x17; ready rises the cycle after adr 7; any upd_vld pulsed during INIT produces no write.
- Single update: adr3, inc 5 at cycle t -> read_0=1/rd_adr_0=3 at t; write_2 adr3 din 0x18 at t+3; a query of adr3 at t+4 returns 0x18 at t+6.
- Hazard: adr2, inc 1 on four consecutive cycles -> writes 0x13, 0x14, 0x15, 0x16 on four consecutive cycles. Repeat with SRAM_DELAY=0: the same values at latency 1.
- Wrap: adr7, inc 0xF0 -> write din 0x07. Then RSTINCR=0x40, NUMADDR=8 init -> adr 4 init value 0x10.
- Same-cycle update and query: adr5 inc 2 plus query adr5 at t -> qry_dout 0x15 at t+2, write 0x17 at t+3; a query at t+1 returns 0x17.
- Reset mid-operation: pulse rst low while three updates are in flight -> no write_2 from dropped updates; ready=0; full re-init restores 0x10..0x17.
